// File: rtl/exu_muldiv_ctrl_pkg.sv
// Shared types and sizing for the MULDIV execution unit controller.
// FSM encodings, op count and iteration count live here; operand width is XLEN.
package exu_muldiv_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PW       = 2 * XLEN;
  localparam int unsigned OP_CNT   = 8;
  localparam int unsigned ITER_CNT = 32;
  localparam int unsigned CNT_W    = $clog2(ITER_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One-hot op select as presented on the interface, MSB first.
  typedef struct packed {
    logic mul;
    logic mulh;
    logic mulhsu;
    logic mulhu;
    logic div;
    logic divu;
    logic rem;
    logic remu;
  } op_t;

  // Decoded operation controls latched at accept.
  typedef struct packed {
    logic sel_lo;
    logic sel_rem;
    logic a_sgn;
    logic b_sgn;
  } ctrl_t;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? XLEN'(~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? XLEN'(~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/exu_muldiv_ctrl_if.sv
// Dispatch/result interface between the issue pipeline and the MULDIV controller.
interface exu_muldiv_ctrl_if;
  import exu_muldiv_ctrl_pkg::*;

  logic            req_muldiv_i;
  logic [XLEN-1:0] muldiv_op1_i;
  logic [XLEN-1:0] muldiv_op2_i;
  logic            op_mul_i;
  logic            op_mulh_i;
  logic            op_mulhsu_i;
  logic            op_mulhu_i;
  logic            op_div_i;
  logic            op_divu_i;
  logic            op_rem_i;
  logic            op_remu_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport slave (
    input  req_muldiv_i, muldiv_op1_i, muldiv_op2_i,
    input  op_mul_i, op_mulh_i, op_mulhsu_i, op_mulhu_i,
    input  op_div_i, op_divu_i, op_rem_i, op_remu_i, flush_i,
    output stall_o, busy_o, result_valid_o, result_o
  );

  modport master (
    output req_muldiv_i, muldiv_op1_i, muldiv_op2_i,
    output op_mul_i, op_mulh_i, op_mulhsu_i, op_mulhu_i,
    output op_div_i, op_divu_i, op_rem_i, op_remu_i, flush_i,
    input  stall_o, busy_o, result_valid_o, result_o
  );

endinterface

// File: rtl/exu_div_iter.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the quotient bit in.
module exu_div_iter
  import exu_muldiv_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_c,
  output logic [XLEN-1:0] quo_c
);

  logic [XLEN:0] shift_c;
  logic [XLEN:0] diff_c;
  logic          fit_c;

  // Partial remainder stays below the divisor, so XLEN+1 bits cover the shift.
  always_comb begin
    shift_c = {rem_i, quo_i[XLEN-1]};
    diff_c  = shift_c - {1'b0, divisor_i};
    fit_c   = ~diff_c[XLEN];
    rem_c   = fit_c ? diff_c[XLEN-1:0] : shift_c[XLEN-1:0];
    quo_c   = {quo_i[XLEN-2:0], fit_c};
  end

endmodule

// File: rtl/exu_muldiv_ctrl.sv
// Multi-cycle RISC-V M-extension controller: FSM, sign handling and result mux.
// Define MULDIV_ITER_MUL_EN for a 32-cycle shift-add multiplier instead of a single-cycle multiply.
module exu_muldiv_ctrl
  import exu_muldiv_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  exu_muldiv_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d, ctrl_in;
  op_t              op_in;
  logic             is_mul_in;
  logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             valid_q, valid_d, busy_q, busy_d;

  logic [XLEN-1:0]  divisor_c, div_rem_c, div_quo_c, mul_res_c;
  logic             res_neg_c, rem_neg_c;

`ifdef MULDIV_ITER_MUL_EN
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d, acc_next_c, prod_c;
`else
  logic signed [XLEN:0]   mul_a_c, mul_b_c;
  logic signed [PW-1:0]   prod_c;
`endif

  // Decode the one-hot op select into sign/result controls.
  always_comb begin
    op_in = {bus.op_mul_i, bus.op_mulh_i, bus.op_mulhsu_i, bus.op_mulhu_i,
             bus.op_div_i, bus.op_divu_i, bus.op_rem_i, bus.op_remu_i};
    is_mul_in       = op_in.mul | op_in.mulh | op_in.mulhsu | op_in.mulhu;
    ctrl_in.sel_lo  = op_in.mul;
    ctrl_in.sel_rem = op_in.rem | op_in.remu;
    ctrl_in.a_sgn   = op_in.mulh | op_in.mulhsu | op_in.div | op_in.rem;
    ctrl_in.b_sgn   = op_in.mulh | op_in.div | op_in.rem;
  end

  always_comb begin
    divisor_c = mag(op2_q, ctrl_q.b_sgn);
    res_neg_c = (ctrl_q.a_sgn & op1_q[XLEN-1]) ^ (ctrl_q.b_sgn & op2_q[XLEN-1]);
    rem_neg_c = ctrl_q.a_sgn & op1_q[XLEN-1];
  end

  exu_div_iter u_div_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_c),
    .rem_c     (div_rem_c),
    .quo_c     (div_quo_c)
  );

`ifdef MULDIV_ITER_MUL_EN
  // Shift-add on magnitudes; the sign is applied to the final accumulation.
  always_comb begin
    acc_next_c = quo_q[0] ? acc_q + mcand_q : acc_q;
    prod_c     = res_neg_c ? PW'(~acc_next_c + 1'b1) : acc_next_c;
    mul_res_c  = ctrl_q.sel_lo ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end
`else
  // 33x33 signed multiply; the extra bit carries each operand's signedness.
  always_comb begin
    mul_a_c   = {ctrl_q.a_sgn & op1_q[XLEN-1], op1_q};
    mul_b_c   = {ctrl_q.b_sgn & op2_q[XLEN-1], op2_q};
    prod_c    = PW'(mul_a_c) * PW'(mul_b_c);
    mul_res_c = ctrl_q.sel_lo ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end
`endif

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
`ifdef MULDIV_ITER_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
`endif
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_muldiv_i) begin
            op1_d  = bus.muldiv_op1_i;
            op2_d  = bus.muldiv_op2_i;
            ctrl_d = ctrl_in;
            cnt_d  = '0;
            if (~|op_in) begin
              state_d  = ST_DONE;
              result_d = '0;
            end else if (is_mul_in) begin
              state_d = ST_MUL;
`ifdef MULDIV_ITER_MUL_EN
              acc_d   = '0;
              mcand_d = PW'(mag(bus.muldiv_op1_i, ctrl_in.a_sgn));
              quo_d   = mag(bus.muldiv_op2_i, ctrl_in.b_sgn);
`endif
            end else if (bus.muldiv_op2_i == '0) begin
              state_d  = ST_DONE;
              result_d = ctrl_in.sel_rem ? bus.muldiv_op1_i : '1;
            end else begin
              state_d = ST_DIV;
              quo_d   = mag(bus.muldiv_op1_i, ctrl_in.a_sgn);
              rem_d   = '0;
            end
          end
        end
        ST_MUL: begin
`ifdef MULDIV_ITER_MUL_EN
          acc_d   = acc_next_c;
          mcand_d = mcand_q << 1;
          quo_d   = quo_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            result_d = mul_res_c;
          end
`else
          state_d  = ST_DONE;
          result_d = mul_res_c;
`endif
        end
        ST_DIV: begin
          quo_d = div_quo_c;
          rem_d = div_rem_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            result_d = ctrl_q.sel_rem ? neg_if(div_rem_c, rem_neg_c)
                                      : neg_if(div_quo_c, res_neg_c);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef MULDIV_ITER_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  assign bus.stall_o        = bus.req_muldiv_i & (state_q != ST_DONE);
  assign bus.busy_o         = busy_q;
  assign bus.result_valid_o = valid_q;
  assign bus.result_o       = result_q;

endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// Scoreboard bench for exu_muldiv_ctrl: directed ops, flush/reset aborts, random ops vs a model.
module tb_exu_muldiv_ctrl;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = 33;
  localparam int OP_NONE = 8;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic req_tb;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  exu_muldiv_ctrl_if bus ();

  exu_muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // op index: 0 mul 1 mulh 2 mulhsu 3 mulhu 4 div 5 divu 6 rem 7 remu 8 none
  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] v;
    v = (op < 8) ? (8'd1 << op) : 8'd0;
    req_tb = 1'b1;
    bus.req_muldiv_i = 1'b1;
    bus.muldiv_op1_i = a;
    bus.muldiv_op2_i = b;
    bus.op_mul_i = v[0]; bus.op_mulh_i = v[1]; bus.op_mulhsu_i = v[2]; bus.op_mulhu_i = v[3];
    bus.op_div_i = v[4]; bus.op_divu_i = v[5]; bus.op_rem_i = v[6]; bus.op_remu_i = v[7];
  endtask

  task automatic idle();
    req_tb = 1'b0;
    bus.req_muldiv_i = 1'b0;
    bus.op_mul_i = 0; bus.op_mulh_i = 0; bus.op_mulhsu_i = 0; bus.op_mulhu_i = 0;
    bus.op_div_i = 0; bus.op_divu_i = 0; bus.op_rem_i = 0; bus.op_remu_i = 0;
  endtask

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
      3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      7: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input int op, input logic [31:0] b);
    if (op == OP_NONE) return 1;
    if (op < 4) return MUL_LAT;
    return (b == 0) ? 1 : DIV_LAT;
  endfunction

  task automatic push(input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Waits for result_valid_o, checking stall_o on every intermediate cycle.
  task automatic wait_result(input string tag, input int drop_at);
    exp_t e;
    int   lat;
    bit   seen;
    e = sb_q.pop_front();
    lat = 0;
    seen = 0;
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (lat == drop_at) begin idle(); #1; end
      if (bus.result_valid_o === 1'b1) seen = 1;
      else begin
        checks++;
        if (bus.stall_o !== req_tb) begin
          errors++;
          $display("FAIL %s stall cycle %0d: got %b expected %b", tag, lat, bus.stall_o, req_tb);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no result_valid_o after %0d cycles", tag, lat);
      return;
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, e.lat);
    end
    checks++;
    if (bus.result_o !== e.res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", tag, bus.result_o, e.res);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s stall in DONE: got %b expected 0", tag, bus.stall_o);
    end
  endtask

  task automatic run_op(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    @(negedge clk);
    drive(op, a, b);
    push(res, lat);
    wait_result(tag, -1);
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.result_o !== 32'd0 || bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h vld=%b busy=%b stall=%b expected all 0",
               bus.result_o, bus.result_valid_o, bus.busy_o, bus.stall_o);
    end
    drive(4, 32'd10, 32'd3);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_req: got %b expected 1", bus.stall_o);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: busy got %b expected 0", bus.busy_o);
    end
    idle();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    @(negedge clk);
    drive(0, 32'd7, 32'd6);
    push(32'd42, MUL_LAT);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_stall_accept: got %b expected 1", bus.stall_o);
    end
    wait_result("mul_7x6", -1);
    idle();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse_end: got vld=%b busy=%b expected 0 0", bus.result_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_mulh();
    run_op("mulhu_ff", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1x2", 2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_m1xm1", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
    run_op("mul_m1xm1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2", 6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100_7", 5, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("remu_100_7", 7, 32'd100, 32'd7, 32'd2, DIV_LAT);
  endtask

  task automatic test_divzero();
    run_op("divu_by0", 5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 7, 32'd100, 32'd0, 32'd100, 1);
    run_op("div_by0", 4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", 6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
    run_op("rem_ovf", 6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LAT);
  endtask

  task automatic test_zero_op();
    run_op("zero_op", OP_NONE, 32'd5, 32'd3, 32'd0, 1);
  endtask

  task automatic test_req_drop();
    @(negedge clk);
    drive(5, 32'd1000, 32'd7);
    push(32'd142, DIV_LAT);
    wait_result("req_drop_divu", 3);
    idle();
  endtask

  task automatic test_flush();
    bit got;
    // flush mid-divide
    @(negedge clk);
    drive(4, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid: got busy=%b vld=%b expected 0 0", bus.busy_o, bus.result_valid_o);
    end
    bus.flush_i = 1'b0;
    got = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid_o === 1'b1) got = 1;
    end
    checks++;
    if (got) begin
      errors++;
      $display("FAIL flush_mid_no_result: got result_valid_o=1 expected none");
    end
    // flush in the cycle that would complete the divide
    drive(5, 32'd1000, 32'd3);
    repeat (32) @(negedge clk);
    bus.flush_i = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_complete: got vld=%b busy=%b expected 0 0", bus.result_valid_o, bus.busy_o);
    end
    bus.flush_i = 1'b0;
    // flush in the accept cycle
    drive(0, 32'd3, 32'd3);
    bus.flush_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: busy got %b expected 0", bus.busy_o);
    end
    bus.flush_i = 1'b0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    run_op("pre_rst_mul", 0, 32'd3, 32'd5, 32'd15, MUL_LAT);
    @(negedge clk);
    drive(4, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.result_o !== 32'd0 || bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got res=%h vld=%b busy=%b stall=%b expected 0 0 0 1",
               bus.result_o, bus.result_valid_o, bus.busy_o, bus.stall_o);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy got %b expected 0", bus.busy_o);
    end
  endtask

  // Next op is presented during DONE; it must not be accepted until IDLE.
  task automatic test_back_to_back();
    @(negedge clk);
    drive(0, 32'd9, 32'd9);
    push(32'd81, MUL_LAT);
    wait_result("b2b_mul", -1);
    drive(5, 32'd81, 32'd9);
    push(32'd9, DIV_LAT + 1);
    wait_result("b2b_divu", -1);
    drive(7, 32'd10, 32'd0);
    push(32'd10, 2);
    wait_result("b2b_remu0", -1);
    idle();
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 8);
      a = $urandom();
      b = $urandom();
      if ((i % 5) == 1) b = 32'd0;
      if ((i % 7) == 3) b = {28'd0, b[3:0]};
      @(negedge clk);
      drive(op, a, b);
      push(model(op, a, b), lat_of(op, b));
      wait_result($sformatf("rand%0d_op%0d", i, op), -1);
      idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_tb = 1'b0;
    bus.flush_i = 1'b0;
    bus.muldiv_op1_i = '0;
    bus.muldiv_op2_i = '0;
    idle();
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_divzero();
    test_overflow();
    test_zero_op();
    test_req_drop();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
